shift_reg_universal: RTL and testbench
======================================

// Module: shift_reg_universal
// PURPOSE
//  Parametrised universal shift register; supersedes the fixed 4-bit PIPO/SIPO/SISO/PISO registers.
//  One instance covers PIPO, SIPO, SISO and PISO use, selected at run time by mode and dir.
//  Adds rotate, a frame bit-counter and a one-cycle frame_done strobe after WIDTH shifts.
//  Sits between parallel datapath registers and serial links/comparators in the test fabric.
// PARAMETERS
//  WIDTH      4    register width in bits; legal range 2..64.
//  RESET_VAL  '0   value loaded into par_out on rst (WIDTH bits).
//  CNT_W      localparam = $clog2(WIDTH); width of shift_cnt.
// PORTS
//  clk         in   1        clock; all state updates on the rising edge.
//  rst         in   1        synchronous, active-high reset.
//  cs          in   1        chip select; 0 = hold everything and ignore mode.
//  mode        in   2        00 HOLD, 01 LOAD, 10 SHIFT, 11 ROTATE.
//  dir         in   1        0 = toward MSB (ser_in enters bit 0); 1 = toward LSB (ser_in enters MSB).
//  par_in      in   WIDTH    parallel load data.
//  ser_in      in   1        serial input bit, used by SHIFT only.
//  par_out     out  WIDTH    register contents (registered).
//  ser_out     out  1        comb: dir=0 -> par_out[WIDTH-1], dir=1 -> par_out[0] (the next bit to leave).
//  shift_cnt   out  CNT_W    shifts done since the last LOAD/reset, modulo WIDTH (registered).
//  frame_done  out  1        registered one-cycle strobe: the WIDTH-th shift of a frame has just completed.
// BEHAVIOUR
//  - Priority per edge: rst > !cs > mode.
//  - Reset: par_out=RESET_VAL, shift_cnt=0, frame_done=0. Reset mid-frame drops the partial frame; no strobe.
//  - cs=0: par_out and shift_cnt hold; frame_done=0.
//  - HOLD: par_out and shift_cnt hold; frame_done=0.
//  - LOAD: par_out<=par_in, shift_cnt<=0, frame_done<=0. One-cycle latency, par_in to par_out.
//  - SHIFT dir=0: par_out <= {par_out[WIDTH-2:0], ser_in}.
//  - SHIFT dir=1: par_out <= {ser_in, par_out[WIDTH-1:1]}.
//  - ROTATE: same as SHIFT, but the bit leaving re-enters at the opposite end; ser_in is ignored.
//  - Counter, SHIFT/ROTATE:
//    - shift_cnt==WIDTH-1: shift_cnt wraps to 0 and frame_done<=1 on the same edge.
//    - otherwise: shift_cnt<=shift_cnt+1, frame_done<=0.
//  - frame_done is never held for two consecutive cycles by one shift. Back-to-back frames give strobes exactly WIDTH shift-cycles apart.
//  - LOAD on the cycle a frame would complete: the load wins, shift_cnt=0, frame_done=0.
//  - dir may change between shifts. The counter ignores dir and counts shift events only.
//  - No X propagation: the mode decode has a default (HOLD) arm.
// STRUCTURE
//  - Package shift_reg_pkg holds:
//    - typedef enum logic [1:0] sr_mode_e {SR_HOLD, SR_LOAD, SR_SHIFT, SR_ROTATE};
//    - localparam SR_DIR_MSB=1'b0, SR_DIR_LSB=1'b1.
//  - One sub-module, frame_bit_counter #(WIDTH):
//    - inputs clk, rst, clr, inc; outputs cnt, wrap_pulse.
//    - It drives shift_cnt and frame_done.
//  - Data path (next-state mux plus par_out flop) stays in the top module.
// TESTING (WIDTH=4, RESET_VAL=0 unless stated)
//  1 PISO: LOAD par_in=4'b1101, then 4x SHIFT dir=0 ser_in=0.
//    -> ser_out before each edge is 1,1,0,1; par_out ends 4'b0000; frame_done=1 only after the 4th edge.
//  2 SIPO: from reset, 4x SHIFT dir=0 with ser_in 0,0,1,1.
//    -> par_out=4'b0011, shift_cnt=0, one frame_done strobe.
//  3 ROTATE: LOAD 4'b1001, 4x ROTATE dir=1.
//    -> par_out sequence 1100, 0110, 0011, 1001; frame_done on the 4th edge only.
//  4 cs/hold: LOAD 4'b1010, then cs=0 for 3 cycles with mode=SHIFT.
//    -> par_out stays 1010, shift_cnt stays 0, frame_done stays 0.
//  5 Mid-frame events, after 2 shifts of a frame:
//    -> rst -> par_out=0, cnt=0, no strobe.
//    -> separately, LOAD 4'b0110 -> cnt=0; the next strobe comes only after 4 further shifts.
//  6 Back-to-back: 8 continuous SHIFTs with WIDTH=8 and RESET_VAL=8'hA5, ser_in=1.
//    -> one strobe on the 8th edge; par_out=8'hFF; shift_cnt=0.

Source files
------------

// File: rtl/shift_reg_universal_pkg.sv
// Shared types and constants for the universal shift register.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        SR_HOLD   = 2'b00,
        SR_LOAD   = 2'b01,
        SR_SHIFT  = 2'b10,
        SR_ROTATE = 2'b11
    } sr_mode_e;

    // Shift direction: toward MSB (ser_in enters bit 0) or toward LSB (ser_in enters MSB).
    localparam logic SR_DIR_MSB = 1'b0;
    localparam logic SR_DIR_LSB = 1'b1;

endpackage

// File: rtl/shift_reg_universal_if.sv
// Control/data bundle between a shift register and its user.
interface shift_reg_universal_if #(
    parameter int WIDTH = 4
);
    import shift_reg_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    logic             cs;
    sr_mode_e         mode;
    logic             dir;
    logic [WIDTH-1:0] par_in;
    logic             ser_in;
    logic [WIDTH-1:0] par_out;
    logic             ser_out;
    logic [CNT_W-1:0] shift_cnt;
    logic             frame_done;

    modport master (
        output cs, mode, dir, par_in, ser_in,
        input  par_out, ser_out, shift_cnt, frame_done
    );

    modport slave (
        input  cs, mode, dir, par_in, ser_in,
        output par_out, ser_out, shift_cnt, frame_done
    );

endinterface

// File: rtl/shift_reg_universal_frame_bit_counter.sv
// Counts shift events modulo WIDTH and strobes once per completed frame.
module frame_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     wrap_pulse
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             wrap_q;

    // Counter and strobe; clr (LOAD) beats a completing shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else if (inc) begin
            if (cnt_q == CNT_MAX) begin
                cnt_q  <= '0;
                wrap_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
                wrap_q <= 1'b0;
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign cnt        = cnt_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, parallel load, shift and rotate in either direction.
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                  clk,
    input logic                  rst,
    shift_reg_universal_if.slave bus
);
    logic [WIDTH-1:0] par_q;
    logic [WIDTH-1:0] par_d;
    logic             cnt_clr;
    logic             cnt_inc;

    // Next-state decode; cs low or an unknown mode falls back to hold.
    always_comb begin
        par_d   = par_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (bus.cs) begin
            case (bus.mode)
                SR_LOAD: begin
                    par_d   = bus.par_in;
                    cnt_clr = 1'b1;
                end
                SR_SHIFT: begin
                    cnt_inc = 1'b1;
                    if (bus.dir == SR_DIR_LSB) par_d = {bus.ser_in, par_q[WIDTH-1:1]};
                    else                       par_d = {par_q[WIDTH-2:0], bus.ser_in};
                end
                SR_ROTATE: begin
                    cnt_inc = 1'b1;
                    if (bus.dir == SR_DIR_LSB) par_d = {par_q[0], par_q[WIDTH-1:1]};
                    else                       par_d = {par_q[WIDTH-2:0], par_q[WIDTH-1]};
                end
                default: par_d = par_q;
            endcase
        end
    end

    // Data register.
    always_ff @(posedge clk) begin
        if (rst) par_q <= RESET_VAL;
        else     par_q <= par_d;
    end

    frame_bit_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .cnt       (bus.shift_cnt),
        .wrap_pulse(bus.frame_done)
    );

    assign bus.par_out = par_q;
    // Next bit to leave depends on the currently requested direction.
    assign bus.ser_out = (bus.dir == SR_DIR_LSB) ? par_q[0] : par_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed bench for shift_reg_universal at WIDTH=4 and WIDTH=8.
module tb_shift_reg_universal;
    import shift_reg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    shift_reg_universal_if #(.WIDTH(4)) if4 ();
    shift_reg_universal_if #(.WIDTH(8)) if8 ();

    shift_reg_universal #(.WIDTH(4), .RESET_VAL(4'b0000)) dut4 (
        .clk(clk), .rst(rst), .bus(if4)
    );
    shift_reg_universal #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk(clk), .rst(rst), .bus(if8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic cs, input sr_mode_e mode, input logic dir,
                          input logic [3:0] pin, input logic sin);
        if4.cs = cs; if4.mode = mode; if4.dir = dir; if4.par_in = pin; if4.ser_in = sin;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive4(1'b0, SR_HOLD, 1'b0, 4'h0, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        if4.cs = 1'b0; if4.mode = SR_HOLD; if4.dir = 1'b0; if4.par_in = '0; if4.ser_in = 1'b0;
        if8.cs = 1'b0; if8.mode = SR_HOLD; if8.dir = 1'b0; if8.par_in = '0; if8.ser_in = 1'b0;
        do_reset();
        total++; if (if4.par_out !== 4'b0000) $display("FAIL reset_par4 got=%b exp=0000", if4.par_out); else passed++;
        total++; if (if4.shift_cnt !== 2'd0) $display("FAIL reset_cnt4 got=%0d exp=0", if4.shift_cnt); else passed++;
        total++; if (if4.frame_done !== 1'b0) $display("FAIL reset_done4 got=%b exp=0", if4.frame_done); else passed++;
        total++; if (if8.par_out !== 8'hA5) $display("FAIL reset_par8 got=%h exp=a5", if8.par_out); else passed++;
    endtask

    task automatic test_piso();
        logic [3:0] exp_ser;
        exp_ser = 4'b1011; // bit i = expected ser_out before shift edge i (1,1,0,1)
        drive4(1'b1, SR_LOAD, SR_DIR_MSB, 4'b1101, 1'b0);
        step();
        total++; if (if4.par_out !== 4'b1101) $display("FAIL piso_load got=%b exp=1101", if4.par_out); else passed++;
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, SR_SHIFT, SR_DIR_MSB, 4'b0000, 1'b0);
            #1;
            total++;
            if (if4.ser_out !== exp_ser[i]) $display("FAIL piso_ser%0d got=%b exp=%b", i, if4.ser_out, exp_ser[i]);
            else passed++;
            step();
            total++;
            if (if4.frame_done !== (i == 3)) $display("FAIL piso_done%0d got=%b exp=%b", i, if4.frame_done, (i == 3));
            else passed++;
        end
        total++; if (if4.par_out !== 4'b0000) $display("FAIL piso_final got=%b exp=0000", if4.par_out); else passed++;
        drive4(1'b1, SR_HOLD, SR_DIR_MSB, 4'b0000, 1'b0);
        step();
        total++; if (if4.frame_done !== 1'b0) $display("FAIL piso_strobe_len got=%b exp=0", if4.frame_done); else passed++;
    endtask

    task automatic test_sipo();
        logic [3:0] bits;
        int         strobes;
        bits    = 4'b1100; // ser_in sequence 0,0,1,1 (bit i used at shift i)
        strobes = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, SR_SHIFT, SR_DIR_MSB, 4'b0000, bits[i]);
            step();
            if (if4.frame_done === 1'b1) strobes++;
        end
        total++; if (if4.par_out !== 4'b0011) $display("FAIL sipo_par got=%b exp=0011", if4.par_out); else passed++;
        total++; if (if4.shift_cnt !== 2'd0) $display("FAIL sipo_cnt got=%0d exp=0", if4.shift_cnt); else passed++;
        total++; if (strobes != 1) $display("FAIL sipo_strobes got=%0d exp=1", strobes); else passed++;
    endtask

    task automatic test_rotate();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
        drive4(1'b1, SR_LOAD, SR_DIR_LSB, 4'b1001, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, SR_ROTATE, SR_DIR_LSB, 4'b0000, 1'b1); // ser_in must be ignored
            step();
            total++;
            if (if4.par_out !== exp_seq[i]) $display("FAIL rot_par%0d got=%b exp=%b", i, if4.par_out, exp_seq[i]);
            else passed++;
            total++;
            if (if4.frame_done !== (i == 3)) $display("FAIL rot_done%0d got=%b exp=%b", i, if4.frame_done, (i == 3));
            else passed++;
        end
        drive4(1'b1, SR_ROTATE, SR_DIR_MSB, 4'b0000, 1'b0);
        step();
        total++; if (if4.par_out !== 4'b0011) $display("FAIL rot_msb got=%b exp=0011", if4.par_out); else passed++;
    endtask

    task automatic test_cs_hold();
        drive4(1'b1, SR_LOAD, SR_DIR_MSB, 4'b1010, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive4(1'b0, SR_SHIFT, SR_DIR_MSB, 4'b0101, 1'b1);
            step();
            total++; if (if4.par_out !== 4'b1010) $display("FAIL cs_par%0d got=%b exp=1010", i, if4.par_out); else passed++;
            total++; if (if4.shift_cnt !== 2'd0) $display("FAIL cs_cnt%0d got=%0d exp=0", i, if4.shift_cnt); else passed++;
            total++; if (if4.frame_done !== 1'b0) $display("FAIL cs_done%0d got=%b exp=0", i, if4.frame_done); else passed++;
        end
    endtask

    task automatic test_mid_frame();
        // Reset after two shifts drops the partial frame.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive4(1'b1, SR_SHIFT, SR_DIR_MSB, 4'b0000, 1'b1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (if4.par_out !== 4'b0000) $display("FAIL mid_rst_par got=%b exp=0000", if4.par_out); else passed++;
        total++; if (if4.shift_cnt !== 2'd0) $display("FAIL mid_rst_cnt got=%0d exp=0", if4.shift_cnt); else passed++;
        total++; if (if4.frame_done !== 1'b0) $display("FAIL mid_rst_done got=%b exp=0", if4.frame_done); else passed++;
        for (int i = 0; i < 2; i++) begin
            drive4(1'b1, SR_SHIFT, SR_DIR_MSB, 4'b0000, 1'b1);
            step();
            total++; if (if4.frame_done !== 1'b0) $display("FAIL mid_rst_after%0d got=%b exp=0", i, if4.frame_done); else passed++;
        end
        total++; if (if4.shift_cnt !== 2'd2) $display("FAIL mid_rst_cnt2 got=%0d exp=2", if4.shift_cnt); else passed++;

        // LOAD mid-frame restarts the count; strobe only after four more shifts.
        drive4(1'b1, SR_LOAD, SR_DIR_MSB, 4'b0110, 1'b0);
        step();
        total++; if (if4.shift_cnt !== 2'd0) $display("FAIL mid_load_cnt got=%0d exp=0", if4.shift_cnt); else passed++;
        total++; if (if4.par_out !== 4'b0110) $display("FAIL mid_load_par got=%b exp=0110", if4.par_out); else passed++;
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, SR_SHIFT, i[0], 4'b0000, 1'b0); // dir toggles; count must not care
            step();
            total++;
            if (if4.frame_done !== (i == 3)) $display("FAIL mid_load_done%0d got=%b exp=%b", i, if4.frame_done, (i == 3));
            else passed++;
        end

        // LOAD on the edge that would complete a frame wins.
        for (int i = 0; i < 3; i++) begin
            drive4(1'b1, SR_SHIFT, SR_DIR_MSB, 4'b0000, 1'b0);
            step();
        end
        total++; if (if4.shift_cnt !== 2'd3) $display("FAIL pre_load_cnt got=%0d exp=3", if4.shift_cnt); else passed++;
        drive4(1'b1, SR_LOAD, SR_DIR_MSB, 4'b1111, 1'b0);
        step();
        total++; if (if4.shift_cnt !== 2'd0) $display("FAIL load_win_cnt got=%0d exp=0", if4.shift_cnt); else passed++;
        total++; if (if4.frame_done !== 1'b0) $display("FAIL load_win_done got=%b exp=0", if4.frame_done); else passed++;
        drive4(1'b0, SR_HOLD, SR_DIR_MSB, 4'b0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        step();
        rst = 1'b0;
        if8.cs = 1'b1; if8.mode = SR_SHIFT; if8.dir = SR_DIR_MSB; if8.ser_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (if8.frame_done !== (i % 8 == 7)) $display("FAIL b2b_done%0d got=%b exp=%b", i, if8.frame_done, (i % 8 == 7));
            else passed++;
            if (i == 7) begin
                total++; if (if8.par_out !== 8'hFF) $display("FAIL b2b_par got=%h exp=ff", if8.par_out); else passed++;
                total++; if (if8.shift_cnt !== 3'd0) $display("FAIL b2b_cnt got=%0d exp=0", if8.shift_cnt); else passed++;
            end
            if (i == 2) begin
                total++; if (if8.par_out !== 8'h2F) $display("FAIL b2b_mid got=%h exp=2f", if8.par_out); else passed++;
            end
        end
        if8.cs = 1'b0;
        step();
        total++; if (if8.frame_done !== 1'b0) $display("FAIL b2b_end got=%b exp=0", if8.frame_done); else passed++;
    endtask

    initial begin
        test_reset();
        test_piso();
        test_sipo();
        test_rotate();
        test_cs_hold();
        test_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
